// File: rtl/puf_pkg.sv
// Shared PUF definitions: response/challenge widths used by the collector
// and the key-expansion stage, plus the collector state encoding.
package puf_pkg;

   localparam int PUF_RESP_WIDTH = 16;
   localparam int PUF_CHAL_WIDTH = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_ERR
   } collector_state_e;

endpackage

// File: rtl/puf_majority_voter.sv
// Counts repeated PUF evaluations of one challenge and majority-votes
// them into a single stable bit.
module puf_majority_voter #(
   parameter int NUM_VOTES = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic sample,
   input  logic puf_bit,
   output logic bit_done,
   output logic voted_bit
);

   localparam int VW = $clog2(NUM_VOTES + 1);

   logic [VW-1:0] vote_cnt;
   logic [VW-1:0] ones_cnt;
   logic [VW-1:0] ones_nxt;

   assign ones_nxt  = ones_cnt + VW'(puf_bit);
   assign bit_done  = sample && (vote_cnt == VW'(NUM_VOTES - 1));
   // The current sample is folded in so the decision lands on the last vote.
   assign voted_bit = ones_nxt > VW'(NUM_VOTES / 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vote_cnt <= '0;
         ones_cnt <= '0;
      end else if (clr || bit_done) begin
         vote_cnt <= '0;
         ones_cnt <= '0;
      end else if (sample) begin
         vote_cnt <= vote_cnt + VW'(1);
         ones_cnt <= ones_nxt;
      end
   end

endmodule

// File: rtl/puf_response_collector.sv
// Sequences challenges into the PUF core, majority-votes the responses and
// hands a stable response plus start pulse to the key-expansion stage.
module puf_response_collector
   import puf_pkg::*;
#(
   parameter int RESP_WIDTH     = PUF_RESP_WIDTH,
   parameter int CHAL_WIDTH     = PUF_CHAL_WIDTH,
   parameter int NUM_VOTES      = 5,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic [CHAL_WIDTH-1:0] challenge_base,
   output logic [CHAL_WIDTH-1:0] puf_challenge,
   output logic                  puf_eval,
   input  logic                  puf_bit,
   input  logic                  puf_bit_valid,
   output logic [RESP_WIDTH-1:0] puf_response,
   output logic                  puf_start,
   output logic                  busy,
   output logic                  error
);

   localparam int BW = $clog2(RESP_WIDTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   collector_state_e      state;
   logic [CHAL_WIDTH-1:0] chal_base;
   logic [BW-1:0]         bit_idx;
   logic [TW-1:0]         tmo_cnt;
   logic [RESP_WIDTH-1:0] asm_q;
   logic [RESP_WIDTH-1:0] asm_nxt;
   logic                  sample;
   logic                  clr;
   logic                  bit_done;
   logic                  voted_bit;
   logic                  last_bit;
   logic                  tmo_hit;

   assign sample   = (state == S_WAIT) && puf_bit_valid;
   assign clr      = (state == S_IDLE) && req;
   assign last_bit = bit_idx == BW'(RESP_WIDTH - 1);
   assign tmo_hit  = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);

   always_comb begin
      asm_nxt          = asm_q;
      asm_nxt[bit_idx] = voted_bit;
   end

   puf_majority_voter #(
      .NUM_VOTES (NUM_VOTES)
   ) u_voter (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .sample    (sample),
      .puf_bit   (puf_bit),
      .bit_done  (bit_done),
      .voted_bit (voted_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         chal_base     <= '0;
         bit_idx       <= '0;
         tmo_cnt       <= '0;
         asm_q         <= '0;
         puf_challenge <= '0;
         puf_eval      <= 1'b0;
         puf_response  <= '0;
         puf_start     <= 1'b0;
         busy          <= 1'b0;
         error         <= 1'b0;
      end else begin
         puf_eval  <= 1'b0;
         puf_start <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req) begin
                  chal_base     <= challenge_base;
                  puf_challenge <= challenge_base;
                  bit_idx       <= '0;
                  asm_q         <= '0;
                  error         <= 1'b0;
                  busy          <= 1'b1;
                  puf_eval      <= 1'b1;
                  state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               tmo_cnt <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               // A valid in the final timeout cycle still counts.
               if (puf_bit_valid) begin
                  if (bit_done && last_bit) begin
                     asm_q        <= asm_nxt;
                     puf_response <= asm_nxt;
                     puf_start    <= 1'b1;
                     state        <= S_DONE;
                  end else begin
                     if (bit_done) begin
                        asm_q         <= asm_nxt;
                        bit_idx       <= bit_idx + BW'(1);
                        puf_challenge <= chal_base
                                       + CHAL_WIDTH'(bit_idx)
                                       + CHAL_WIDTH'(1);
                     end
                     puf_eval <= 1'b1;
                     state    <= S_ISSUE;
                  end
               end else if (tmo_hit) begin
                  error <= 1'b1;
                  state <= S_ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            S_DONE, S_ERR: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench for the PUF response collector with a behavioural PUF
// that answers each evaluate strobe after a programmable latency.
module tb_puf_response_collector;

   logic        clk;
   logic        rst;
   logic        req;
   logic [7:0]  challenge_base;
   logic [7:0]  puf_challenge;
   logic        puf_eval;
   logic        puf_bit;
   logic        puf_bit_valid;
   logic [15:0] puf_response;
   logic        puf_start;
   logic        busy;
   logic        error;

   puf_response_collector dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .challenge_base (challenge_base),
      .puf_challenge  (puf_challenge),
      .puf_eval       (puf_eval),
      .puf_bit        (puf_bit),
      .puf_bit_valid  (puf_bit_valid),
      .puf_response   (puf_response),
      .puf_start      (puf_start),
      .busy           (busy),
      .error          (error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // PUF model knobs
   int   mode      = 0;
   int   inv       = 0;
   bit   spur      = 1'b0;
   int   mute_from = 1000;
   int   long_idx  = -1;
   int   long_lat  = 1;
   logic [7:0] chal_log [16];

   function automatic logic model_bit(input logic [7:0] ch, input int ev);
      logic b;
      int v;
      int bi;
      v  = ev % 5;
      bi = ev / 5;
      b  = (mode == 0) ? ch[0] : (ch >= 8'hF8);
      if (inv == 1 && v < 2) b = ~b;
      if (inv == 2 && bi == 0 && v < 3) b = ~b;
      return b;
   endfunction

   initial begin
      int         ev;
      int         age;
      int         lat_cur;
      int         idx_cur;
      bit         pend;
      logic [7:0] chal_cur;
      ev = 0; age = 0; lat_cur = 1; idx_cur = 0; pend = 1'b0; chal_cur = '0;
      puf_bit_valid = 1'b0;
      puf_bit = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         puf_bit_valid = 1'b0;
         puf_bit = 1'b0;
         if (pend) begin
            age++;
            if (age == lat_cur) begin
               pend = 1'b0;
               puf_bit_valid = 1'b1;
               puf_bit = model_bit(chal_cur, idx_cur);
            end
         end else if (spur) begin
            puf_bit_valid = 1'b1;
            puf_bit = 1'b1;
         end
         @(negedge clk);
         if (!busy) begin
            ev = 0;
            pend = 1'b0;
         end else if (puf_eval) begin
            chal_cur = puf_challenge;
            idx_cur = ev;
            if (ev % 5 == 0 && ev / 5 < 16) chal_log[ev/5] = puf_challenge;
            lat_cur = (ev == long_idx) ? long_lat : 1;
            if (ev < mute_from) begin
               pend = 1'b1;
               age = 0;
            end
            ev++;
         end
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   int starts, start_k, err_k, end_k;
   bit err1, ended;

   task automatic run(input logic [7:0] base, input bit extra_req,
                      input int abort_at);
      starts = 0; start_k = -1; err_k = -1; end_k = -1;
      err1 = 1'b1; ended = 1'b0;
      @(negedge clk);
      challenge_base = base;
      req = 1'b1;
      for (int k = 1; k < 4000; k++) begin
         @(negedge clk);
         req = extra_req && (k == 5 || k == 50 || k == 161);
         if (k == 1) err1 = error;
         if (puf_start) begin
            starts++;
            start_k = k;
         end
         if (error && err_k < 0) err_k = k;
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            chk("rst_outputs",
                {puf_challenge, puf_eval, puf_response, puf_start, busy, error},
                '0);
            @(negedge clk);
            rst = 1'b0;
            ended = 1'b1;
            break;
         end
         if (!busy) begin
            end_k = k;
            ended = 1'b1;
            break;
         end
      end
      req = 1'b0;
      chk("run_bound", 32'(ended), 1);
   endtask

   task automatic chal_check(input logic [7:0] base, input string nm);
      int bad;
      logic [7:0] e;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         e = base + 8'(i);
         if (chal_log[i] !== e) bad++;
      end
      chk(nm, bad, 0);
   endtask

   typedef struct {
      logic [7:0]  base;
      int          mode;
      int          inv;
      bit          spur;
      logic [15:0] resp;
      int          cyc;
   } vec_t;

   vec_t vt [6];

   initial begin
      rst = 1'b1;
      req = 1'b0;
      challenge_base = '0;
      for (int i = 0; i < 16; i++) chal_log[i] = '0;

      vt[0] = '{8'h00, 0, 0, 1'b0, 16'hAAAA, 161};
      vt[1] = '{8'h00, 0, 1, 1'b0, 16'hAAAA, 161};
      vt[2] = '{8'h00, 0, 2, 1'b0, 16'hAAAB, 161};
      vt[3] = '{8'hF8, 1, 0, 1'b0, 16'h00FF, 161};
      vt[4] = '{8'h01, 0, 0, 1'b0, 16'h5555, 161};
      vt[5] = '{8'h00, 0, 0, 1'b1, 16'hAAAA, 161};

      repeat (2) @(negedge clk);
      chk("reset_outputs",
          {puf_challenge, puf_eval, puf_response, puf_start, busy, error}, '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int t = 0; t < 6; t++) begin
         mode = vt[t].mode;
         inv  = vt[t].inv;
         spur = vt[t].spur;
         run(vt[t].base, 1'b0, -1);
         spur = 1'b0;
         chk($sformatf("v%0d_resp", t), 32'(puf_response), 32'(vt[t].resp));
         chk($sformatf("v%0d_start_cyc", t), start_k, vt[t].cyc);
         chk($sformatf("v%0d_starts", t), starts, 1);
         chk($sformatf("v%0d_busy_low", t), end_k, vt[t].cyc + 1);
         chk($sformatf("v%0d_error", t), 32'(error), 0);
         chal_check(vt[t].base, $sformatf("v%0d_chal_seq", t));
      end
      mode = 0;
      inv  = 0;

      // timeout at bit 3 after a good run
      run(8'h00, 1'b0, -1);
      chk("pre_tmo_resp", 32'(puf_response), 32'hAAAA);
      mute_from = 15;
      run(8'h00, 1'b0, -1);
      mute_from = 1000;
      chk("tmo_err_cyc", err_k, 96);
      chk("tmo_starts", starts, 0);
      chk("tmo_resp_held", 32'(puf_response), 32'hAAAA);
      chk("tmo_busy_low", end_k, 97);
      @(negedge clk);
      chk("tmo_err_sticky", 32'(error), 1);
      run(8'h00, 1'b0, -1);
      chk("tmo_err_cleared", 32'(err1), 0);
      chk("tmo_recover_resp", 32'(puf_response), 32'hAAAA);
      chk("tmo_recover_cyc", start_k, 161);

      // req pulses while busy and in DONE
      run(8'h01, 1'b1, -1);
      chk("busy_req_starts", starts, 1);
      chk("busy_req_cyc", start_k, 161);
      chk("busy_req_resp", 32'(puf_response), 32'h5555);
      repeat (3) @(negedge clk);
      chk("busy_req_idle", 32'(busy), 0);

      // valid lands in the 64th WAIT cycle of the first evaluation
      long_idx = 0;
      long_lat = 64;
      run(8'h00, 1'b0, -1);
      long_idx = -1;
      chk("edge_tmo_error", 32'(error), 0);
      chk("edge_tmo_cyc", start_k, 224);
      chk("edge_tmo_resp", 32'(puf_response), 32'hAAAA);

      // reset mid-collection, then a full run
      mode = 1;
      run(8'hF8, 1'b0, -1);
      mode = 0;
      chk("pre_rst_resp", 32'(puf_response), 32'h00FF);
      run(8'h10, 1'b0, 80);
      chk("abort_starts", starts, 0);
      run(8'h00, 1'b0, -1);
      chk("post_rst_resp", 32'(puf_response), 32'hAAAA);
      chk("post_rst_cyc", start_k, 161);
      chk("post_rst_starts", starts, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
